// File: rtl/vx_icache_rsp_demux.sv
// Routes icache core responses to per-requester FIFOs selected by low tag bits.
// Optional perf counters enabled by defining VX_ICACHE_RSP_DEMUX_PERF_EN.
module vx_icache_rsp_demux #(
    parameter int NUM_OUTPUTS = 4,
    parameter int WORD_SIZE   = 4,
    parameter int TAG_WIDTH   = 8,
    parameter int DEPTH       = 2,
    localparam int SEL_BITS   = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 0,
    localparam int DW         = 8 * WORD_SIZE,
    localparam int TOW        = TAG_WIDTH - SEL_BITS,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       rsp_in_valid,
    input  logic [DW-1:0]              rsp_in_data,
    input  logic [TAG_WIDTH-1:0]       rsp_in_tag,
    output logic                       rsp_in_ready,
    output logic [NUM_OUTPUTS-1:0]     rsp_out_valid,
    output logic [NUM_OUTPUTS*DW-1:0]  rsp_out_data,
    output logic [NUM_OUTPUTS*TOW-1:0] rsp_out_tag,
    input  logic [NUM_OUTPUTS-1:0]     rsp_out_ready,
    output logic [NUM_OUTPUTS*CW-1:0]  rsp_out_count
`ifdef VX_ICACHE_RSP_DEMUX_PERF_EN
    ,
    output logic [31:0]                perf_stall_cycles,
    output logic [31:0]                perf_rsp_count
`endif
);

    localparam int SW = (SEL_BITS > 0) ? SEL_BITS : 1;
    localparam int PW = $clog2(DEPTH);

    logic [SW-1:0]          sel;
    logic [TOW-1:0]         tag_s;
    logic [NUM_OUTPUTS-1:0] full;
    logic [NUM_OUTPUTS-1:0] push;

    generate
        if (SEL_BITS > 0) begin : g_sel
            assign sel = rsp_in_tag[SW-1:0];
        end else begin : g_nosel
            assign sel = '0;
        end
    endgenerate

    assign tag_s = rsp_in_tag[TAG_WIDTH-1:SEL_BITS];

    // Out-of-range selects fall through with ready high and are dropped.
    always_comb begin
        rsp_in_ready = 1'b1;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (sel == SW'(i)) rsp_in_ready = !full[i];
        end
    end

    generate
        for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_out
            logic [PW-1:0]  wr_ptr;
            logic [PW-1:0]  rd_ptr;
            logic [CW-1:0]  count;
            logic [DW-1:0]  data_q [DEPTH];
            logic [TOW-1:0] tag_q  [DEPTH];
            logic           pop;

            assign full[i] = (count == CW'(DEPTH));
            assign push[i] = rsp_in_valid && (sel == SW'(i)) && !full[i];
            assign pop     = (count != '0) && rsp_out_ready[i];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                end else begin
                    if (push[i]) wr_ptr <= wr_ptr + PW'(1);
                    if (pop) rd_ptr <= rd_ptr + PW'(1);
                    if (push[i] && !pop) count <= count + CW'(1);
                    else if (pop && !push[i]) count <= count - CW'(1);
                end
            end

            // Payload storage is intentionally left unreset.
            always_ff @(posedge clk) begin
                if (push[i]) begin
                    data_q[wr_ptr] <= rsp_in_data;
                    tag_q[wr_ptr]  <= tag_s;
                end
            end

            assign rsp_out_valid[i]          = (count != '0);
            assign rsp_out_data[i*DW +: DW]  = data_q[rd_ptr];
            assign rsp_out_tag[i*TOW +: TOW] = tag_q[rd_ptr];
            assign rsp_out_count[i*CW +: CW] = count;
        end
    endgenerate

`ifdef VX_ICACHE_RSP_DEMUX_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_cycles <= '0;
            perf_rsp_count    <= '0;
        end else begin
            if (rsp_in_valid && !rsp_in_ready)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (|push)
                perf_rsp_count <= perf_rsp_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vx_icache_rsp_demux.sv
// Directed vector bench for vx_icache_rsp_demux (4-output and 3-output builds).
module tb_vx_icache_rsp_demux;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;

    logic         v = 1'b0;
    logic [31:0]  data = '0;
    logic [7:0]   tag = '0;
    logic         rdy;
    logic [3:0]   oval;
    logic [127:0] odata;
    logic [23:0]  otag;
    logic [3:0]   ordy = '0;
    logic [7:0]   ocnt;

    logic         b_v = 1'b0;
    logic [31:0]  b_data = '0;
    logic [7:0]   b_tag = '0;
    logic         b_rdy;
    logic [2:0]   b_val;
    logic [95:0]  b_odata;
    logic [17:0]  b_otag;
    logic [2:0]   b_ordy = '0;
    logic [5:0]   b_cnt;

`ifdef VX_ICACHE_RSP_DEMUX_PERF_EN
    logic [31:0]  a_stall, a_rsp, b_stall, b_rsp;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vx_icache_rsp_demux u0 (
        .clk(clk), .reset_n(reset_n),
        .rsp_in_valid(v), .rsp_in_data(data), .rsp_in_tag(tag),
        .rsp_in_ready(rdy), .rsp_out_valid(oval), .rsp_out_data(odata),
        .rsp_out_tag(otag), .rsp_out_ready(ordy), .rsp_out_count(ocnt)
`ifdef VX_ICACHE_RSP_DEMUX_PERF_EN
        , .perf_stall_cycles(a_stall), .perf_rsp_count(a_rsp)
`endif
    );

    vx_icache_rsp_demux #(.NUM_OUTPUTS(3)) u3 (
        .clk(clk), .reset_n(reset_n),
        .rsp_in_valid(b_v), .rsp_in_data(b_data), .rsp_in_tag(b_tag),
        .rsp_in_ready(b_rdy), .rsp_out_valid(b_val), .rsp_out_data(b_odata),
        .rsp_out_tag(b_otag), .rsp_out_ready(b_ordy), .rsp_out_count(b_cnt)
`ifdef VX_ICACHE_RSP_DEMUX_PERF_EN
        , .perf_stall_cycles(b_stall), .perf_rsp_count(b_rsp)
`endif
    );

    typedef struct {
        logic        v;
        logic [7:0]  tag;
        logic [31:0] data;
        logic [3:0]  ordy;
        logic        e_rdy;
        logic [3:0]  e_val;
        logic [7:0]  e_cnt;
        int          ch;
        logic [31:0] e_data;
        logic [5:0]  e_tag;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 4'h0, 8'h00, -1, 32'h0,        6'h00};
        vecs[1]  = '{1'b1, 8'h2D, 32'hDEADBEEF, 4'h0, 1'b1, 4'h0, 8'h00, -1, 32'h0,        6'h00};
        vecs[2]  = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 4'h2, 8'h04,  1, 32'hDEADBEEF, 6'h0B};
        vecs[3]  = '{1'b0, 8'h00, 32'h0,        4'h2, 1'b1, 4'h2, 8'h04,  1, 32'hDEADBEEF, 6'h0B};
        vecs[4]  = '{1'b1, 8'h00, 32'h11111111, 4'h0, 1'b1, 4'h0, 8'h00, -1, 32'h0,        6'h00};
        vecs[5]  = '{1'b1, 8'h04, 32'h22222222, 4'h0, 1'b1, 4'h1, 8'h01,  0, 32'h11111111, 6'h00};
        vecs[6]  = '{1'b1, 8'h08, 32'h33333333, 4'h0, 1'b0, 4'h1, 8'h02,  0, 32'h11111111, 6'h00};
        vecs[7]  = '{1'b1, 8'h03, 32'h44444444, 4'h0, 1'b1, 4'h1, 8'h02,  0, 32'h11111111, 6'h00};
        vecs[8]  = '{1'b1, 8'h08, 32'h33333333, 4'h1, 1'b0, 4'h9, 8'h42,  3, 32'h44444444, 6'h00};
        vecs[9]  = '{1'b1, 8'h08, 32'h33333333, 4'h1, 1'b1, 4'h9, 8'h41,  0, 32'h22222222, 6'h01};
        vecs[10] = '{1'b0, 8'h00, 32'h0,        4'h1, 1'b1, 4'h9, 8'h41,  0, 32'h33333333, 6'h02};
        vecs[11] = '{1'b0, 8'h00, 32'h0,        4'h8, 1'b1, 4'h8, 8'h40,  3, 32'h44444444, 6'h00};
        vecs[12] = '{1'b1, 8'h06, 32'hA0A0A0A0, 4'h0, 1'b1, 4'h0, 8'h00, -1, 32'h0,        6'h00};
        vecs[13] = '{1'b1, 8'h0A, 32'hA1A1A1A1, 4'h0, 1'b1, 4'h4, 8'h10,  2, 32'hA0A0A0A0, 6'h01};
        vecs[14] = '{1'b1, 8'h0E, 32'hA2A2A2A2, 4'h4, 1'b0, 4'h4, 8'h20,  2, 32'hA0A0A0A0, 6'h01};
        vecs[15] = '{1'b1, 8'h0E, 32'hA2A2A2A2, 4'h0, 1'b1, 4'h4, 8'h10,  2, 32'hA1A1A1A1, 6'h02};
        vecs[16] = '{1'b0, 8'h00, 32'h0,        4'h4, 1'b1, 4'h4, 8'h20,  2, 32'hA1A1A1A1, 6'h02};
        vecs[17] = '{1'b0, 8'h00, 32'h0,        4'h4, 1'b1, 4'h4, 8'h10,  2, 32'hA2A2A2A2, 6'h03};
        vecs[18] = '{1'b0, 8'h00, 32'h0,        4'hF, 1'b1, 4'h0, 8'h00, -1, 32'h0,        6'h00};
        vecs[19] = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 4'h0, 8'h00, -1, 32'h0,        6'h00};

        // Reset state
        #12;
        chk("rst_ready", 64'(rdy), 64'h1);
        chk("rst_valid", 64'(oval), 64'h0);
        chk("rst_count", 64'(ocnt), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            v = vecs[k].v;
            tag = vecs[k].tag;
            data = vecs[k].data;
            ordy = vecs[k].ordy;
            #1;
            chk($sformatf("v%0d_ready", k), 64'(rdy), 64'(vecs[k].e_rdy));
            chk($sformatf("v%0d_valid", k), 64'(oval), 64'(vecs[k].e_val));
            chk($sformatf("v%0d_count", k), 64'(ocnt), 64'(vecs[k].e_cnt));
            if (vecs[k].ch >= 0) begin
                chk($sformatf("v%0d_data", k),
                    64'(odata[vecs[k].ch*32 +: 32]), 64'(vecs[k].e_data));
                chk($sformatf("v%0d_tag", k),
                    64'(otag[vecs[k].ch*6 +: 6]), 64'(vecs[k].e_tag));
            end
        end

        // Mid-stream reset with two entries buffered on out0
        @(negedge clk);
        v = 1'b1; tag = 8'h00; data = 32'h55555555; ordy = 4'h0;
        @(negedge clk);
        data = 32'h66666666;
        @(negedge clk);
        data = 32'h77777777;
        #1;
        chk("pre_rst_count", 64'(ocnt), 64'h02);
        chk("pre_rst_ready", 64'(rdy), 64'h0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(oval), 64'h0);
        chk("mid_rst_count", 64'(ocnt), 64'h0);
        chk("mid_rst_ready", 64'(rdy), 64'h1);
        @(negedge clk);
        reset_n = 1'b1;
        v = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_valid", 64'(oval), 64'h0);
        chk("post_rst_count", 64'(ocnt), 64'h0);

        // Three-output build: out-of-range select is dropped
        @(negedge clk);
        b_v = 1'b1; b_tag = 8'h03; b_data = 32'hCAFE0003; b_ordy = 3'b000;
        #1;
        chk("oor_ready", 64'(b_rdy), 64'h1);
        @(negedge clk);
        b_tag = 8'h01; b_data = 32'hCAFE0001;
        #1;
        chk("oor_valid", 64'(b_val), 64'h0);
        chk("oor_count", 64'(b_cnt), 64'h0);
        chk("b1_ready", 64'(b_rdy), 64'h1);
        @(negedge clk);
        b_tag = 8'h00; b_data = 32'hCAFE0000;
        #1;
        chk("b1_valid", 64'(b_val), 64'h2);
        chk("b1_count", 64'(b_cnt), 64'h04);
        chk("b1_data", 64'(b_odata[32 +: 32]), 64'hCAFE0001);
        chk("b1_tag", 64'(b_otag[6 +: 6]), 64'h00);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("b0_full_count", 64'(b_cnt), 64'h06);
        chk("b0_full_ready", 64'(b_rdy), 64'h0);
        repeat (5) @(negedge clk);
        b_v = 1'b0;
        #1;
        chk("b0_stall_count", 64'(b_cnt), 64'h06);
`ifdef VX_ICACHE_RSP_DEMUX_PERF_EN
        chk("perf_stall", 64'(b_stall), 64'd5);
        chk("perf_rsp", 64'(b_rsp), 64'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vx_icache_rsp_demux.md
Name: vx_icache_rsp_demux

Overview:
Parametrised icache response channel successor: accepts one core-side icache response stream (valid/data/tag/ready) and routes each response to one of NUM_OUTPUTS requester channels, selected by the low tag bits. Each output has its own elastic FIFO, so a stalled requester does not block responses bound for others once they are buffered. Sits between the icache core response port and per-warp/per-fetch-unit consumers.

Parameters:
NUM_OUTPUTS, 4, number of output channels (>=1)
WORD_SIZE, 4, response word size in bytes; DW = 8*WORD_SIZE
TAG_WIDTH, 8, input tag width; must be > SEL_BITS
DEPTH, 2, per-output FIFO depth, power of two, >=2
SEL_BITS, derived, clog2(NUM_OUTPUTS), 0 when NUM_OUTPUTS==1
TOW, derived, output tag width = TAG_WIDTH - SEL_BITS

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
rsp_in_valid  in  1  input response valid
rsp_in_data  in  DW  input response word
rsp_in_tag  in  TAG_WIDTH  input tag; [SEL_BITS-1:0] = output select
rsp_in_ready  out  1  input accepted this cycle when high with valid
rsp_out_valid  out  NUM_OUTPUTS  per-output valid
rsp_out_data  out  NUM_OUTPUTS*DW  per-output word, channel i at [i*DW +: DW]
rsp_out_tag  out  NUM_OUTPUTS*TOW  per-output tag = rsp_in_tag[TAG_WIDTH-1:SEL_BITS]
rsp_out_ready  in  NUM_OUTPUTS  per-output consumer ready
rsp_out_count  out  NUM_OUTPUTS*clog2(DEPTH+1)  per-output FIFO occupancy

Behaviour:
- sel = rsp_in_tag[SEL_BITS-1:0] (0 if SEL_BITS==0).
- sel < NUM_OUTPUTS: rsp_in_ready = !full[sel]; combinational on tag and FIFO state only, never on rsp_in_valid or rsp_out_ready.
- sel >= NUM_OUTPUTS (non-power-of-two NUM_OUTPUTS): rsp_in_ready = 1, response discarded, no FIFO modified.
- Push: rsp_in_valid && rsp_in_ready writes {data, stripped tag} at wr_ptr[sel]; wr_ptr wraps modulo DEPTH.
- Pop: rsp_out_valid[i] && rsp_out_ready[i] advances rd_ptr[i], wrapping modulo DEPTH.
- rsp_out_valid[i] = (count[i] != 0); data/tag driven from storage at rd_ptr[i] (registered storage, no input bypass).
- Latency: response accepted in cycle N is visible on its output at cycle N+1 at the earliest; FIFO order preserved per output, no ordering between outputs.
- Full FIFO with simultaneous pop: no push that cycle (ready uses full only); count goes DEPTH -> DEPTH-1.
- Simultaneous push and pop on the same non-full, non-empty FIFO: count unchanged, both pointers advance.
- Empty FIFO: rsp_out_ready ignored, no pointer movement.
- rsp_out_count[i] = count[i], range 0..DEPTH.
- Reset (asynchronous, any cycle including mid-transfer): all pointers and counts = 0, rsp_out_valid = 0, rsp_out_count = 0, rsp_in_ready = 1 while in reset; buffered responses lost. Storage contents not reset.
- No state machine beyond per-FIFO pointer/count state; all outputs glitch-free relative to clk.

Optional Feature:
VX_ICACHE_RSP_DEMUX_PERF_EN
- Defined: adds outputs perf_stall_cycles (32) and perf_rsp_count (32). perf_stall_cycles increments each cycle rsp_in_valid && !rsp_in_ready; perf_rsp_count increments on each accepted in-range response. Both wrap at 2^32 and reset to 0 on reset_n low.
- Not defined: ports absent, no counters synthesised; all other behaviour identical.

Test Plan:
- Reset: hold reset_n=0 mid-stream with 2 entries buffered on out0 -> rsp_out_valid=0000, counts=0, rsp_in_ready=1; after release, out0 stays empty.
- Routing: NUM_OUTPUTS=4, push tag=0x2D (sel=1) data=0xDEADBEEF -> cycle after accept rsp_out_valid=0010, out1 data=0xDEADBEEF, tag=0x0B.
- Backpressure: rsp_out_ready[0]=0, push 3 responses with sel=0, DEPTH=2 -> first two accepted, third sees rsp_in_ready=0, count[0]=2; set ready -> drains in order, third accepted after first pop.
- Isolation: out0 full and stalled, push sel=3 -> accepted immediately, out3 valid next cycle.
- Full plus pop: count[2]=2, rsp_out_ready[2]=1, push sel=2 same cycle -> not accepted, count[2]=1; retry next cycle accepted, count[2]=2.
- Out-of-range/perf: NUM_OUTPUTS=3, push sel=3 -> rsp_in_ready=1, no output change; with PERF_EN, 5 stalled cycles -> perf_stall_cycles=5.
